// File: rtl/comparador_serial.sv
// Multi-cycle WIDTH-bit magnitude comparator, one SLICE-bit digit per cycle, MSB first, 7485-style cascade.
// Optional COMPARADOR_SERIAL_EARLY_EXIT_EN: finish right after the first unequal slice.
module comparador_serial #(
    parameter int WIDTH  = 24,
    parameter int SLICE  = 6,
    parameter int SIGNED = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ALBi,
    input  logic             AGBi,
    input  logic             AEBi,
    output logic             ALBo,
    output logic             AGBo,
    output logic             AEBo,
    output logic             ocupado,
    output logic             pronto,
    output logic [1:0]       estado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } state_t;

    localparam int NSLICES = WIDTH / SLICE;
    localparam int IW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NSLICES - 1);
    // Flipping the sign bit of both operands turns a two's-complement compare into an unsigned one.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    state_t           state, state_n;
    logic [IW-1:0]    idx;
    logic             decided;
    logic             dec_lt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       casc_q;

    logic [SLICE-1:0] slice_a, slice_b;
    logic             slice_lt, slice_ne;
    logic             res_dec, res_lt;

    always_comb begin
        slice_a  = a_q[idx*SLICE +: SLICE];
        slice_b  = b_q[idx*SLICE +: SLICE];
        slice_lt = (slice_a < slice_b);
        slice_ne = (slice_a != slice_b);
        // An earlier decision always wins over the current slice.
        res_dec  = decided | slice_ne;
        res_lt   = decided ? dec_lt : slice_lt;
    end

    always_comb begin
        state_n = state;
        case (state)
            OCIOSO: begin
                if (iniciar) state_n = COMPARA;
            end
            COMPARA: begin
                if (idx == '0) begin
                    state_n = FIM;
                end
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
                else if (slice_ne) begin
                    state_n = FIM;
                end
`endif
            end
            FIM: begin
                state_n = OCIOSO;
            end
            default: begin
                state_n = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= OCIOSO;
            idx     <= TOP_IDX;
            decided <= 1'b0;
            dec_lt  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            ALBo    <= 1'b0;
            AGBo    <= 1'b0;
            AEBo    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                OCIOSO: begin
                    if (iniciar) begin
                        a_q     <= A ^ SIGN_FLIP;
                        b_q     <= B ^ SIGN_FLIP;
                        casc_q  <= {ALBi, AGBi, AEBi};
                        idx     <= TOP_IDX;
                        decided <= 1'b0;
                    end
                end
                COMPARA: begin
                    if (!decided && slice_ne) begin
                        decided <= 1'b1;
                        dec_lt  <= slice_lt;
                    end
                    if (idx != '0) idx <= idx - IW'(1);
                    // Results land on the edge entering FIM so they are valid with pronto.
                    if (state_n == FIM) begin
                        if (res_dec) begin
                            ALBo <= res_lt;
                            AGBo <= ~res_lt;
                            AEBo <= 1'b0;
                        end else begin
                            {ALBo, AGBo, AEBo} <= casc_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (state != OCIOSO);
    assign pronto  = (state == FIM);
    assign estado  = state;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial: unsigned and signed instances driven with the same vectors.
module tb_comparador_serial;

    localparam int W = 24;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         iniciar = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         albi = 1'b0, agbi = 1'b0, aebi = 1'b0;

    logic u_alb, u_agb, u_aeb, u_ocup, u_pronto;
    logic s_alb, s_agb, s_aeb, s_ocup, s_pronto;
    logic [1:0] u_est, s_est;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    comparador_serial #(.WIDTH(W), .SLICE(6), .SIGNED(0)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .A(a), .B(b),
        .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
        .ALBo(u_alb), .AGBo(u_agb), .AEBo(u_aeb),
        .ocupado(u_ocup), .pronto(u_pronto), .estado(u_est)
    );

    comparador_serial #(.WIDTH(W), .SLICE(6), .SIGNED(1)) dut_s (
        .clock(clock), .reset(reset), .iniciar(iniciar), .A(a), .B(b),
        .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
        .ALBo(s_alb), .AGBo(s_agb), .AEBo(s_aeb),
        .ocupado(s_ocup), .pronto(s_pronto), .estado(s_est)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // j = position of first unequal slice (0 = top), N when operands are equal
    function automatic int exp_lat(input int j);
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
        return (j < N) ? j + 2 : N + 1;
`else
        return N + 1;
`endif
    endfunction

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   casc;   // {ALBi, AGBi, AEBi}
        logic [2:0]   exp_u;  // {ALBo, AGBo, AEBo}
        logic [2:0]   exp_s;
        int           j;
    } vec_t;

    vec_t vecs[10];

    // Called at a negedge; returns at the negedge of the first idle cycle after FIM.
    task automatic run(input vec_t v, input string tag);
        int cnt;
        logic [2:0] eu, es;
        a = v.va; b = v.vb; {albi, agbi, aebi} = v.casc; iniciar = 1'b1;
        exp_q.push_back(v.exp_u);
        exp_q.push_back(v.exp_s);
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        a = W'($urandom); b = W'($urandom); {albi, agbi, aebi} = 3'($urandom);
        cnt = 1;
        while (u_pronto !== 1'b1 && cnt < 20) begin
            chk({tag, " ocupado"}, {31'd0, u_ocup}, 32'd1);
            @(negedge clock);
            cnt++;
        end
        chk({tag, " latency"}, cnt, exp_lat(v.j));
        chk({tag, " ocupado_fim"}, {31'd0, u_ocup}, 32'd1);
        chk({tag, " s_pronto"}, {31'd0, s_pronto}, 32'd1);
        eu = exp_q.pop_front();
        es = exp_q.pop_front();
        chk({tag, " res_u"}, {29'd0, u_alb, u_agb, u_aeb}, {29'd0, eu});
        chk({tag, " res_s"}, {29'd0, s_alb, s_agb, s_aeb}, {29'd0, es});
        @(negedge clock);
        chk({tag, " idle"}, {30'd0, u_pronto, u_ocup}, 32'd0);
        chk({tag, " held"}, {29'd0, u_alb, u_agb, u_aeb}, {29'd0, eu});
    endtask

    initial begin
        int npr, first;
        logic [2:0] res;

        vecs[0] = '{24'h123456, 24'h123457, 3'b000, 3'b100, 3'b100, 3};
        vecs[1] = '{24'h800000, 24'h000001, 3'b000, 3'b010, 3'b100, 0};
        vecs[2] = '{24'hABCDEF, 24'hABCDEF, 3'b001, 3'b001, 3'b001, 4};
        vecs[3] = '{24'hABCDEF, 24'hABCDEF, 3'b100, 3'b100, 3'b100, 4};
        vecs[4] = '{24'h000005, 24'h000009, 3'b000, 3'b100, 3'b100, 3};
        vecs[5] = '{24'hFFFFFF, 24'h000000, 3'b000, 3'b010, 3'b100, 0};
        vecs[6] = '{24'h7FFFFF, 24'h800000, 3'b000, 3'b100, 3'b010, 0};
        vecs[7] = '{24'h000000, 24'h000000, 3'b111, 3'b111, 3'b111, 4};
        vecs[8] = '{24'h000FC0, 24'h000000, 3'b000, 3'b010, 3'b010, 2};
        vecs[9] = '{24'h040000, 24'h03FFFF, 3'b001, 3'b010, 3'b010, 0};

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_out", {27'd0, u_alb, u_agb, u_aeb, u_ocup, u_pronto}, 32'd0);
        chk("reset_state", {30'd0, u_est}, 32'd0);
        chk("reset_out_s", {27'd0, s_alb, s_agb, s_aeb, s_ocup, s_pronto}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // table, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // start while busy is ignored
        a = 24'd5; b = 24'd9; {albi, agbi, aebi} = 3'b000; iniciar = 1'b1;
        @(posedge clock);
        npr = 0; first = 0; res = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (u_pronto === 1'b1) begin
                npr++;
                if (first == 0) begin
                    first = c;
                    res = {u_alb, u_agb, u_aeb};
                end
            end
            iniciar = (c == 2);
            if (c == 2) begin a = 24'd9; b = 24'd5; end
        end
        chk("busy_npronto", npr, 1);
        chk("busy_latency", first, exp_lat(3));
        chk("busy_res", {29'd0, res}, {29'd0, 3'b100});

        // back-to-back pair
        run('{24'd5, 24'd9, 3'b000, 3'b100, 3'b100, 3}, "b2b_a");
        run('{24'd9, 24'd5, 3'b000, 3'b010, 3'b010, 3}, "b2b_b");

        // reset mid-operation
        a = 24'h123456; b = 24'h123457; iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_u", {27'd0, u_alb, u_agb, u_aeb, u_ocup, u_pronto}, 32'd0);
        chk("midrst_s", {27'd0, s_alb, s_agb, s_aeb, s_ocup, s_pronto}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        npr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (u_pronto !== 1'b0 || u_ocup !== 1'b0) npr++;
        end
        chk("post_rst_quiet", npr, 0);

        run(vecs[1], "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparador_serial.md
Name: comparador_serial

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands, cascadable like a 7485.
- Operands are captured on a start pulse and compared one SLICE-bit digit per cycle, MSB slice first.
- Registered ALB/AGB/AEB results come with a busy/done handshake.
- Used in datapaths where a wide single-cycle compare would limit clock rate; optional signed mode.

Parameters:
- WIDTH, 24, operand width in bits; must be a multiple of SLICE.
- SLICE, 6, bits compared per cycle; NSLICES = WIDTH/SLICE (>=1).
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start; sampled only in OCIOSO.
- A  in  WIDTH  operand A; captured when start is accepted.
- B  in  WIDTH  operand B; captured when start is accepted.
- ALBi  in  1  cascade less-than input; captured with operands.
- AGBi  in  1  cascade greater-than input; captured with operands.
- AEBi  in  1  cascade equal input; captured with operands.
- ALBo  out  1  registered result A<B.
- AGBo  out  1  registered result A>B.
- AEBo  out  1  registered result A==B (qualified by cascade).
- ocupado  out  1  high while a compare is in progress (COMPARA or FIM).
- pronto  out  1  one-cycle pulse; results valid and updated.

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO, slice index = NSLICES-1, decided flag cleared. ALBo, AGBo, AEBo, ocupado, pronto all 0.
- FSM states:
  - OCIOSO: iniciar=1 latches A, B, ALBi, AGBi, AEBi; index <= NSLICES-1; decided <= 0; next state COMPARA.
  - COMPARA: compare the latched A and B slices at the current index, unsigned SLICE-bit compare.
    - SIGNED=1: invert the MSB of both operands in the top slice before comparing.
    - First unequal slice sets the decided flag and records L (A slice < B slice) or G (A slice > B slice). Later slices never override it.
    - Index decrements each cycle. When index==0, or on decision with early exit, next state is FIM.
  - FIM: pronto=1 for exactly this cycle; results written; next state OCIOSO.
- Result encoding, written on the FIM cycle and held until the next FIM:
  - Decided L: ALBo=1, AGBo=0, AEBo=0.
  - Decided G: ALBo=0, AGBo=1, AEBo=0.
  - All slices equal: ALBo=ALBi, AGBo=AGBi, AEBo=AEBi, using the latched cascade values. No cascade priority logic; bits pass through unchanged.
- Latency (iniciar sampled at edge k):
  - Top slice compared in cycle k+1.
  - Without early exit, pronto is high in cycle k+1+NSLICES.
- ocupado=1 from cycle k+1 through the FIM cycle inclusive; 0 in OCIOSO.
- iniciar while ocupado=1 is ignored; latched operands are unaffected.
- Operand inputs may change freely after capture.
- Back-to-back operation: iniciar in the first OCIOSO cycle after FIM starts a new compare. Minimum period is NSLICES+2 cycles.
- NSLICES=1: single COMPARA cycle, then FIM.
- Reset mid-operation: immediate return to OCIOSO with all outputs 0. No pronto is produced for the aborted compare.

Optional Feature:
- Macro: COMPARADOR_SERIAL_EARLY_EXIT_EN.
- Defined: COMPARA goes to FIM in the cycle after the first unequal slice. For a difference at slice position j (0 = top), pronto is high in cycle k+2+j. Equal operands still take NSLICES compare cycles.
- Undefined: always NSLICES compare cycles; latency is constant.

Test Plan (WIDTH=24, SLICE=6, SIGNED=0 unless stated):
1. A=0x123456, B=0x123457, iniciar at k -> ALBo=1, AGBo=0, AEBo=0, pronto pulse in cycle k+5 in both builds; ocupado high k+1..k+5.
2. A=0x800000, B=0x000001 -> AGBo=1. Pronto at k+2 with EARLY_EXIT_EN, k+5 without. Same operands with SIGNED=1 -> ALBo=1.
3. A=B=0xABCDEF, AEBi=1, ALBi=0, AGBi=0 -> AEBo=1. Repeat with AEBi=0, ALBi=1 -> ALBo=1, AEBo=0, AGBo=0.
4. Start A=5, B=9; at k+2 pulse iniciar with A=9, B=5 -> ignored; single pronto, ALBo=1. Then new iniciar right after FIM -> AGBo=1 after NSLICES+1 cycles.
5. Start compare; drive reset=0 at k+3 (between edges) -> ocupado, ALBo, AGBo, AEBo drop to 0 immediately; no pronto after reset release until a new iniciar.
